melody_sequencer: RTL and testbench

Plays short fixed melodies (score, round-start, win jingles) on the game's square-wave tone generator. It arbitrates three event requesters and steps each melody's notes through the 4-bit tone code with beat-accurate durations and inter-note gaps. It sits between game control logic and the tone generator's `tone` input.

---
 rtl/sound_pkg.sv | 54 +++++
 rtl/melody_rom.sv | 16 +
 rtl/melody_sequencer.sv | 139 +++++++++++++
 tb/tb_melody_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sound_pkg : tone codes, melody ROM entry layout and melody contents   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sound_pkg;

   localparam logic [3:0] TONE_NONE = 4'd0;
   localparam logic [3:0] TONE_C4   = 4'd8;
   localparam logic [3:0] TONE_D4   = 4'd9;
   localparam logic [3:0] TONE_E4   = 4'd10;
   localparam logic [3:0] TONE_F4   = 4'd11;
   localparam logic [3:0] TONE_G4   = 4'd12;
   localparam logic [3:0] TONE_A4   = 4'd13;
   localparam logic [3:0] TONE_B4   = 4'd14;
   localparam logic [3:0] TONE_C5   = 4'd15;

   localparam logic [1:0] DUR_1 = 2'd0;
   localparam logic [1:0] DUR_2 = 2'd1;
   localparam logic [1:0] DUR_4 = 2'd2;
   localparam logic [1:0] DUR_8 = 2'd3;

   typedef struct packed {
      logic [3:0] tone;
      logic [1:0] dur;
      logic       last;
   } rom_entry_t;

   function automatic logic [3:0] dur_beats(input logic [1:0] dur);
      return 4'd1 << dur;
   endfunction

   // Unused slots read as a silent terminating entry so a stray index always ends the melody.
   function automatic rom_entry_t melody_entry(input logic [1:0] mel, input logic [2:0] idx);
      rom_entry_t e;
      e = '{TONE_NONE, DUR_1, 1'b1};
      case ({mel, idx})
         5'b00_000: e = '{TONE_C4, DUR_1, 1'b0};
         5'b00_001: e = '{TONE_E4, DUR_1, 1'b1};
         5'b01_000: e = '{TONE_C4, DUR_1, 1'b0};
         5'b01_001: e = '{TONE_E4, DUR_1, 1'b0};
         5'b01_010: e = '{TONE_G4, DUR_1, 1'b0};
         5'b01_011: e = '{TONE_C5, DUR_2, 1'b1};
         5'b10_000: e = '{TONE_G4, DUR_1, 1'b0};
         5'b10_001: e = '{TONE_G4, DUR_1, 1'b0};
         5'b10_010: e = '{TONE_G4, DUR_1, 1'b0};
         5'b10_011: e = '{TONE_C5, DUR_4, 1'b1};
         default: ;
      endcase
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/melody_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | melody_rom : combinational {melody, note index} -> 7-bit entry lookup |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module melody_rom
   import sound_pkg::*;
(
   input  logic [4:0] addr,
   output logic [6:0] entry
);

   assign entry = melody_entry(addr[4:3], addr[2:0]);

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | melody_sequencer : arbitrates melody requests and steps ROM notes     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module melody_sequencer
   import sound_pkg::*;
#(
   parameter int BEAT_CYCLES = 6250000,
   parameter int GAP_CYCLES  = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [3:0] tone,
   output logic       busy,
   output logic [1:0] active,
   output logic       done
);

   // Counter must also cover a gap longer than the longest note.
   localparam int c_max_cnt = (8 * BEAT_CYCLES > GAP_CYCLES) ? 8 * BEAT_CYCLES : GAP_CYCLES;
   localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
   localparam logic [c_cnt_w-1:0] c_beat    = c_cnt_w'(BEAT_CYCLES);
   localparam bit                 c_has_gap = (GAP_CYCLES > 0);
   localparam logic [c_cnt_w-1:0] c_gap_end = c_has_gap ? c_cnt_w'(GAP_CYCLES - 1) : '0;

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_note = 2'd1;
   localparam logic [1:0] c_gap  = 2'd2;

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_idx;
   logic [1:0]         r_dur;
   logic               r_last;
   logic [2:0]         r_pend;
   logic [3:0]         r_tone;
   logic               r_busy;
   logic [1:0]         r_active;
   logic               r_done;

   logic [2:0]         w_reqs;
   logic               w_any;
   logic [1:0]         w_win;
   logic [2:0]         w_win_mask;
   logic               w_preempt;
   logic [c_cnt_w-1:0] w_note_end;
   logic               w_note_over;
   logic               w_boundary;
   logic               w_start;
   logic               w_advance;
   logic               w_to_gap;
   logic               w_to_idle;
   logic [4:0]         w_rom_addr;
   logic [6:0]         w_rom_data;
   rom_entry_t         w_next;
   logic [2:0]         w_pend_next;

   assign w_reqs = r_pend | req;
   assign w_any  = |w_reqs;

   always_comb begin
      w_win = 2'd0;
      if (w_reqs[2])      w_win = 2'd2;
      else if (w_reqs[1]) w_win = 2'd1;
   end

   assign w_win_mask = 3'b001 << w_win;
   // The winner is the highest pending index, so it outranks active exactly when some request does.
   assign w_preempt  = w_any && (w_win > r_active);

   assign w_note_end  = c_cnt_w'(dur_beats(r_dur)) * c_beat - c_cnt_w'(1);
   assign w_note_over = (r_state == c_note) && (r_cnt == w_note_end);
   assign w_boundary  = c_has_gap ? ((r_state == c_gap) && (r_cnt == c_gap_end)) : w_note_over;
   assign w_to_gap    = w_note_over && c_has_gap;

   assign w_start   = ((r_state == c_idle) && w_any)
                    || (w_boundary && (w_preempt || (r_last && w_any)));
   assign w_advance = w_boundary && !w_preempt && !r_last;
   assign w_to_idle = w_boundary && r_last && !w_any;

   assign w_rom_addr  = w_start ? {w_win, 3'd0} : {r_active, r_idx + 3'd1};
   assign w_next      = rom_entry_t'(w_rom_data);
   assign w_pend_next = w_reqs & ~(w_start ? w_win_mask : 3'b000);

   melody_rom u_rom (
      .addr  (w_rom_addr),
      .entry (w_rom_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= c_idle;
         r_cnt    <= '0;
         r_idx    <= 3'd0;
         r_dur    <= 2'd0;
         r_last   <= 1'b0;
         r_pend   <= 3'b000;
         r_tone   <= TONE_NONE;
         r_busy   <= 1'b0;
         r_active <= 2'd0;
         r_done   <= 1'b0;
      end else begin
         r_pend <= w_pend_next;
         r_done <= w_boundary && r_last && !w_preempt;
         if (w_start || w_advance) begin
            r_state <= c_note;
            r_cnt   <= '0;
            r_idx   <= w_start ? 3'd0 : r_idx + 3'd1;
            if (w_start) r_active <= w_win;
            r_tone  <= w_next.tone;
            r_dur   <= w_next.dur;
            r_last  <= w_next.last;
            r_busy  <= 1'b1;
         end else if (w_to_gap) begin
            r_state <= c_gap;
            r_cnt   <= '0;
            r_tone  <= TONE_NONE;
         end else if (w_to_idle) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_tone   <= TONE_NONE;
            r_busy   <= 1'b0;
            r_active <= 2'd0;
         end else if (r_state != c_idle) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign tone   = r_tone;
   assign busy   = r_busy;
   assign active = r_active;
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_melody_sequencer : scoreboard bench, one DUT with gaps, one without|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_melody_sequencer;

   localparam int BEAT = 10;
   localparam int GAP  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req_a, req_b;
   logic [3:0] tone_a, tone_b;
   logic       busy_a, busy_b, done_a, done_b;
   logic [1:0] active_a, active_b;

   always #5 clk = ~clk;

   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) u_dut_gap (
      .clk(clk), .rst(rst), .req(req_a),
      .tone(tone_a), .busy(busy_a), .active(active_a), .done(done_a)
   );

   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(0)) u_dut_nogap (
      .clk(clk), .rst(rst), .req(req_b),
      .tone(tone_b), .busy(busy_b), .active(active_b), .done(done_b)
   );

   typedef struct packed {
      logic [3:0] tone;
      logic       busy;
      logic [1:0] active;
      logic       done;
   } obs_t;

   obs_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   sel    = 1'b0;

   task automatic push(input logic [3:0] t, input logic b, input logic [1:0] a,
                       input logic d, input int n);
      for (int i = 0; i < n; i++) q.push_back('{t, b, a, d});
   endtask

   task automatic push_melody(input int m, input int gap, input int nnotes);
      int tones[4];
      int beats[4];
      int cnt;
      case (m)
         0:       begin tones = '{8, 10, 0, 0};   beats = '{1, 1, 0, 0}; cnt = 2; end
         1:       begin tones = '{8, 10, 12, 15}; beats = '{1, 1, 1, 2}; cnt = 4; end
         default: begin tones = '{12, 12, 12, 15}; beats = '{1, 1, 1, 4}; cnt = 4; end
      endcase
      for (int i = 0; i < cnt && i < nnotes; i++) begin
         push(4'(tones[i]), 1'b1, 2'(m), 1'b0, beats[i] * BEAT);
         push(4'd0, 1'b1, 2'(m), 1'b0, gap);
      end
   endtask

   task automatic push_end();
      push(4'd0, 1'b0, 2'd0, 1'b1, 1);
      push(4'd0, 1'b0, 2'd0, 1'b0, 3);
   endtask

   task automatic mark_done(input int pos);
      obs_t e;
      e      = q[pos];
      e.done = 1'b1;
      q[pos] = e;
   endtask

   // Step once per clock until the scoreboard drains; req/rst are changed after cycle i's check.
   task automatic run(input string tag, input int jreq, input logic [2:0] vreq, input int jrst);
      obs_t obs;
      obs_t exp;
      int   i;
      i = 0;
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         obs = sel ? obs_t'{tone_b, busy_b, active_b, done_b}
                   : obs_t'{tone_a, busy_a, active_a, done_a};
         exp = q.pop_front();
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed tone=%0d busy=%0b active=%0d done=%0b, expected tone=%0d busy=%0b active=%0d done=%0b",
                   tag, i, obs.tone, obs.busy, obs.active, obs.done,
                   exp.tone, exp.busy, exp.active, exp.done);
         end
         if (sel) req_b = (i == jreq) ? vreq : 3'b000;
         else     req_a = (i == jreq) ? vreq : 3'b000;
         rst = (i == jrst);
         i++;
      end
   endtask

   initial begin
      int pos;
      rst   = 1'b1;
      req_a = 3'b000;
      req_b = 3'b000;

      // Reset state
      push(4'd0, 1'b0, 2'd0, 1'b0, 4);
      run("reset", -1, 3'b000, -1);

      // Melody 0 from a single-cycle request
      req_a = 3'b001;
      push_melody(0, GAP, 2);
      push_end();
      run("mel0", -1, 3'b000, -1);

      // Melody 1
      req_a = 3'b010;
      push_melody(1, GAP, 4);
      push_end();
      run("mel1", -1, 3'b000, -1);

      // Melody 0 preempted by melody 2 requested on cycle 3
      req_a = 3'b001;
      push_melody(0, GAP, 1);
      push_melody(2, GAP, 4);
      push_end();
      run("preempt", 2, 3'b100, -1);

      // Simultaneous 0 and 1: 1 first, 0 back-to-back on the done edge
      req_a = 3'b011;
      push_melody(1, GAP, 4);
      pos = q.size();
      push_melody(0, GAP, 2);
      mark_done(pos);
      push_end();
      run("b2b", -1, 3'b000, -1);

      // Reset mid-note with a pending request discards everything
      req_a = 3'b001;
      push(4'd8, 1'b1, 2'd0, 1'b0, 5);
      push(4'd0, 1'b0, 2'd0, 1'b0, 40);
      run("midreset", 2, 3'b010, 4);

      // No-gap instance
      sel   = 1'b1;
      req_b = 3'b001;
      push_melody(0, 0, 2);
      push_end();
      run("nogap", -1, 3'b000, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
